// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS EX stage: operand forwarding, ALU, iterative multiplier, EX/DM register
//
// Purpose: selects operands from the register file or the forwarding paths,
// executes the decoded op (single-cycle ALU, or shift-add multiply over
// DATA_WIDTH cycles) and registers result plus memory/writeback controls.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   op_dec_i, imm_i, imm_sel_i decoded opcode, immediate, B = extended imm
//   mux_sel_a_i, mux_sel_b_i  operand source: 00/11 rf, 01 alu_out_o, 10 dm_data_i
//   rf_a_i, rf_b_i, dm_data_i register file read data, DM-stage forward data
//   rw_ex_i, wb_en_ex_i, mem_en_ex_i, mem_rw_ex_i  destination and controls
//   alu_out_o, store_o        registered result/address, store data
//   rw_o, wb_en_o, mem_en_o, mem_rw_o  registered destination and controls
//   zero_o, ovf_o             registered result==0, signed ADD/SUB overflow
//   stall_o                   upstream must hold inputs and PC
module execute_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [5:0]                op_dec_i,
  input  logic [IMM_WIDTH-1:0]      imm_i,
  input  logic                      imm_sel_i,
  input  logic [1:0]                mux_sel_a_i,
  input  logic [1:0]                mux_sel_b_i,
  input  logic [DATA_WIDTH-1:0]     rf_a_i,
  input  logic [DATA_WIDTH-1:0]     rf_b_i,
  input  logic [DATA_WIDTH-1:0]     dm_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] rw_ex_i,
  input  logic                      wb_en_ex_i,
  input  logic                      mem_en_ex_i,
  input  logic                      mem_rw_ex_i,
  output logic [DATA_WIDTH-1:0]     alu_out_o,
  output logic [DATA_WIDTH-1:0]     store_o,
  output logic [REG_ADDR_WIDTH-1:0] rw_o,
  output logic                      wb_en_o,
  output logic                      mem_en_o,
  output logic                      mem_rw_o,
  output logic                      zero_o,
  output logic                      ovf_o,
  output logic                      stall_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_XOR = 6'h04;
  localparam logic [5:0] OP_NOR = 6'h05;
  localparam logic [5:0] OP_SLT = 6'h06;
  localparam logic [5:0] OP_SLL = 6'h07;
  localparam logic [5:0] OP_SRL = 6'h08;
  localparam logic [5:0] OP_SRA = 6'h09;
  localparam logic [5:0] OP_LUI = 6'h0A;
  localparam logic [5:0] OP_MUL = 6'h0B;

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_MUL_DONE} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     alu_out_q, alu_out_d;
  logic [DATA_WIDTH-1:0]     store_q, store_d;
  logic [REG_ADDR_WIDTH-1:0] rw_q, rw_d;
  logic                      wb_en_q, wb_en_d;
  logic                      mem_en_q, mem_en_d;
  logic                      mem_rw_q, mem_rw_d;
  logic                      zero_q, zero_d;
  logic                      ovf_q, ovf_d;

  // Multiplier working registers and the captured copy of the held MUL.
  logic [DATA_WIDTH-1:0]     mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]     mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     cap_store_q, cap_store_d;
  logic [REG_ADDR_WIDTH-1:0] cap_rw_q, cap_rw_d;
  logic                      cap_wb_q, cap_wb_d;
  logic                      cap_mem_en_q, cap_mem_en_d;
  logic                      cap_mem_rw_q, cap_mem_rw_d;

  logic [DATA_WIDTH-1:0]     opa, fwd_b, opb, imm_ext, result, add_res, sub_res;
  logic                      ovf;
  logic [SHW-1:0]            shamt;

  // Operand selection and single-cycle ALU.
  always_comb begin
    opa = rf_a_i;
    case (mux_sel_a_i)
      2'b01:   opa = alu_out_q;
      2'b10:   opa = dm_data_i;
      default: opa = rf_a_i;
    endcase
    fwd_b = rf_b_i;
    case (mux_sel_b_i)
      2'b01:   fwd_b = alu_out_q;
      2'b10:   fwd_b = dm_data_i;
      default: fwd_b = rf_b_i;
    endcase
    // Logical ops take an unsigned immediate; everything else sign-extends.
    if (op_dec_i >= OP_AND && op_dec_i <= OP_NOR)
      imm_ext = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_i};
    else
      imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm_i[IMM_WIDTH-1]}}, imm_i};
    opb     = imm_sel_i ? imm_ext : fwd_b;
    shamt   = opb[SHW-1:0];
    add_res = opa + opb;
    sub_res = opa - opb;
    result  = '0;
    ovf     = 1'b0;
    case (op_dec_i)
      OP_ADD: begin
        result = add_res;
        ovf    = (opa[DATA_WIDTH-1] == opb[DATA_WIDTH-1]) &&
                 (add_res[DATA_WIDTH-1] != opa[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        result = sub_res;
        ovf    = (opa[DATA_WIDTH-1] != opb[DATA_WIDTH-1]) &&
                 (sub_res[DATA_WIDTH-1] != opa[DATA_WIDTH-1]);
      end
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_NOR:  result = ~(opa | opb);
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLL:  result = opa << shamt;
      OP_SRL:  result = opa >> shamt;
      OP_SRA:  result = $unsigned($signed(opa) >>> shamt);
      OP_LUI:  result = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm_i} << 16;
      default: result = '0;
    endcase
  end

  // FSM next state, stall and pipeline-register next values.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    alu_out_d    = alu_out_q;
    store_d      = store_q;
    rw_d         = rw_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    mem_rw_d     = mem_rw_q;
    wb_en_d      = 1'b0;
    mem_en_d     = 1'b0;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    cap_store_d  = cap_store_q;
    cap_rw_d     = cap_rw_q;
    cap_wb_d     = cap_wb_q;
    cap_mem_en_d = cap_mem_en_q;
    cap_mem_rw_d = cap_mem_rw_q;
    case (state_q)
      S_IDLE: begin
        if (op_dec_i == OP_MUL) begin
          stall_o      = 1'b1;
          mcand_d      = opa;
          mplier_d     = opb;
          acc_d        = '0;
          cnt_d        = '0;
          cap_store_d  = fwd_b;
          cap_rw_d     = rw_ex_i;
          cap_wb_d     = wb_en_ex_i;
          cap_mem_en_d = mem_en_ex_i;
          cap_mem_rw_d = mem_rw_ex_i;
          state_d      = S_MUL_RUN;
        end else begin
          alu_out_d = result;
          store_d   = fwd_b;
          rw_d      = rw_ex_i;
          wb_en_d   = wb_en_ex_i;
          mem_en_d  = mem_en_ex_i;
          mem_rw_d  = mem_rw_ex_i;
          zero_d    = (result == '0);
          ovf_d     = ovf;
        end
      end
      S_MUL_RUN: begin
        stall_o  = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Fixed iteration count, even for zero operands.
        if (cnt_q == CW'(DATA_WIDTH - 1)) state_d = S_MUL_DONE;
      end
      S_MUL_DONE: begin
        alu_out_d = acc_q;
        store_d   = cap_store_q;
        rw_d      = cap_rw_q;
        wb_en_d   = cap_wb_q;
        mem_en_d  = cap_mem_en_q;
        mem_rw_d  = cap_mem_rw_q;
        zero_d    = (acc_q == '0);
        ovf_d     = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      alu_out_q    <= '0;
      store_q      <= '0;
      rw_q         <= '0;
      wb_en_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_rw_q     <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      cap_store_q  <= '0;
      cap_rw_q     <= '0;
      cap_wb_q     <= 1'b0;
      cap_mem_en_q <= 1'b0;
      cap_mem_rw_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_out_q    <= alu_out_d;
      store_q      <= store_d;
      rw_q         <= rw_d;
      wb_en_q      <= wb_en_d;
      mem_en_q     <= mem_en_d;
      mem_rw_q     <= mem_rw_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      cap_store_q  <= cap_store_d;
      cap_rw_q     <= cap_rw_d;
      cap_wb_q     <= cap_wb_d;
      cap_mem_en_q <= cap_mem_en_d;
      cap_mem_rw_q <= cap_mem_rw_d;
    end
  end

  assign alu_out_o = alu_out_q;
  assign store_o   = store_q;
  assign rw_o      = rw_q;
  assign wb_en_o   = wb_en_q;
  assign mem_en_o  = mem_en_q;
  assign mem_rw_o  = mem_rw_q;
  assign zero_o    = zero_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  sa, sb;
  logic [31:0] ra, rb, dm;
  logic [4:0]  rw;
  logic        wb, me, mrw;
  logic [31:0] alu, store;
  logic [4:0]  rw_q;
  logic        wb_q, me_q, mrw_q, zero_q, ovf_q, stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk_i(clk), .reset_i(reset), .op_dec_i(op), .imm_i(imm), .imm_sel_i(imm_sel),
    .mux_sel_a_i(sa), .mux_sel_b_i(sb), .rf_a_i(ra), .rf_b_i(rb), .dm_data_i(dm),
    .rw_ex_i(rw), .wb_en_ex_i(wb), .mem_en_ex_i(me), .mem_rw_ex_i(mrw),
    .alu_out_o(alu), .store_o(store), .rw_o(rw_q), .wb_en_o(wb_q), .mem_en_o(me_q),
    .mem_rw_o(mrw_q), .zero_o(zero_q), .ovf_o(ovf_q), .stall_o(stall)
  );

  task automatic idle_inputs();
    op = 6'h00; imm = 16'h0; imm_sel = 1'b0; sa = 2'b00; sb = 2'b00;
    ra = 32'h0; rb = 32'h0; dm = 32'h0; rw = 5'd0; wb = 1'b0; me = 1'b0; mrw = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); tick();
    reset = 1'b0;
    op = 6'h00; ra = 32'd1; rb = 32'd1; rw = 5'd3; wb = 1'b1; me = 1'b1; mrw = 1'b1;
    tick();
    n_tests++;
    if (alu !== 32'd2) begin n_fail++; $display("FAIL pre_reset_add: got %h expected %h", alu, 32'd2); end
    reset = 1'b1; tick(); reset = 1'b0; idle_inputs();
    n_tests++;
    if ({alu, store, rw_q, wb_q, me_q, mrw_q, zero_q, ovf_q} !== 75'd0) begin
      n_fail++; $display("FAIL reset_outputs: got alu=%h store=%h rw=%0d wb=%b me=%b mrw=%b z=%b o=%b expected all 0",
                         alu, store, rw_q, wb_q, me_q, mrw_q, zero_q, ovf_q);
    end
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
  endtask

  task automatic test_add_sub();
    idle_inputs(); op = 6'h00; ra = 32'd5; rb = 32'd7; rw = 5'd4; wb = 1'b1;
    tick();
    n_tests++;
    if (alu !== 32'd12) begin n_fail++; $display("FAIL add: got %h expected %h", alu, 32'd12); end
    n_tests++;
    if (rw_q !== 5'd4 || wb_q !== 1'b1) begin n_fail++; $display("FAIL add_ctrl: got rw=%0d wb=%b expected rw=4 wb=1", rw_q, wb_q); end
    op = 6'h01; sa = 2'b01; rb = 32'd20;
    tick();
    n_tests++;
    if (alu !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL sub_fwd_ex: got %h expected %h", alu, 32'hFFFFFFF8); end
    n_tests++;
    if (zero_q !== 1'b0 || ovf_q !== 1'b0) begin n_fail++; $display("FAIL sub_flags: got z=%b o=%b expected z=0 o=0", zero_q, ovf_q); end
  endtask

  task automatic test_forward_dm();
    idle_inputs(); op = 6'h00; sb = 2'b10; dm = 32'h100; imm_sel = 1'b1; imm = 16'hFFFC;
    ra = 32'h200; rb = 32'hDEAD; me = 1'b1; mrw = 1'b1; rw = 5'd7;
    tick();
    n_tests++;
    if (alu !== 32'h1FC) begin n_fail++; $display("FAIL fwd_dm_alu: got %h expected %h", alu, 32'h1FC); end
    n_tests++;
    if (store !== 32'h100) begin n_fail++; $display("FAIL fwd_dm_store: got %h expected %h", store, 32'h100); end
    n_tests++;
    if (me_q !== 1'b1 || mrw_q !== 1'b1 || ovf_q !== 1'b0) begin
      n_fail++; $display("FAIL fwd_dm_ctrl: got me=%b mrw=%b o=%b expected 1 1 0", me_q, mrw_q, ovf_q);
    end
  endtask

  task automatic test_logic_imm();
    idle_inputs(); op = 6'h03; ra = 32'h0; imm_sel = 1'b1; imm = 16'h8001;
    tick();
    n_tests++;
    if (alu !== 32'h00008001) begin n_fail++; $display("FAIL or_zext: got %h expected %h", alu, 32'h00008001); end
    op = 6'h0A; imm = 16'h1234; ra = 32'hFFFFFFFF;
    tick();
    n_tests++;
    if (alu !== 32'h12340000) begin n_fail++; $display("FAIL lui: got %h expected %h", alu, 32'h12340000); end
    op = 6'h06; imm_sel = 1'b0; ra = 32'hFFFFFFFF; rb = 32'd1;
    tick();
    n_tests++;
    if (alu !== 32'd1) begin n_fail++; $display("FAIL slt_signed: got %h expected %h", alu, 32'd1); end
    op = 6'h09; ra = 32'h80000000; rb = 32'h00000024;
    tick();
    n_tests++;
    if (alu !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h expected %h", alu, 32'hF8000000); end
    op = 6'h3F; ra = 32'h55; rb = 32'h66; wb = 1'b1; rw = 5'd12;
    tick();
    n_tests++;
    if (alu !== 32'd0 || zero_q !== 1'b1 || wb_q !== 1'b1 || rw_q !== 5'd12) begin
      n_fail++; $display("FAIL undef_op: got alu=%h z=%b wb=%b rw=%0d expected 0 1 1 12", alu, zero_q, wb_q, rw_q);
    end
  endtask

  task automatic test_back_to_back_mul();
    int cnt;
    bit hold_ok, bubble_ok;
    idle_inputs(); op = 6'h00; ra = 32'd3; rb = 32'd4; wb = 1'b1;
    tick();
    op = 6'h0B; ra = 32'd7; rb = 32'd6; rw = 5'd9; wb = 1'b1; me = 1'b0;
    #1;
    cnt = 0; hold_ok = 1'b1; bubble_ok = 1'b1;
    while (stall === 1'b1 && cnt < 40) begin
      cnt++; tick();
      if (alu !== 32'd7) hold_ok = 1'b0;
      if (wb_q !== 1'b0 || me_q !== 1'b0) bubble_ok = 1'b0;
    end
    n_tests++;
    if (cnt !== 33) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 33", cnt); end
    n_tests++;
    if (!hold_ok) begin n_fail++; $display("FAIL mul_hold: got alu=%h expected held 7", alu); end
    n_tests++;
    if (!bubble_ok) begin n_fail++; $display("FAIL mul_bubble: got wb/me nonzero expected 0 during stall"); end
    tick();
    n_tests++;
    if (alu !== 32'd42 || wb_q !== 1'b1 || rw_q !== 5'd9) begin
      n_fail++; $display("FAIL mul_result: got alu=%0d wb=%b rw=%0d expected 42 1 9", alu, wb_q, rw_q);
    end
    ra = 32'h80000000; rb = 32'd2; rw = 5'd10;
    #1;
    cnt = 0; hold_ok = 1'b1;
    while (stall === 1'b1 && cnt < 40) begin
      cnt++; tick();
      if (alu !== 32'd42) hold_ok = 1'b0;
    end
    n_tests++;
    if (cnt !== 33 || !hold_ok) begin n_fail++; $display("FAIL mul2_stall: got cycles=%0d hold=%b expected 33 1", cnt, hold_ok); end
    tick();
    idle_inputs();
    n_tests++;
    if (alu !== 32'd0 || zero_q !== 1'b1 || rw_q !== 5'd10) begin
      n_fail++; $display("FAIL mul2_result: got alu=%h z=%b rw=%0d expected 0 1 10", alu, zero_q, rw_q);
    end
  endtask

  task automatic test_overflow();
    idle_inputs(); op = 6'h00; ra = 32'h7FFFFFFF; rb = 32'd1;
    tick();
    n_tests++;
    if (alu !== 32'h80000000 || ovf_q !== 1'b1) begin
      n_fail++; $display("FAIL add_ovf: got alu=%h o=%b expected 80000000 1", alu, ovf_q);
    end
    op = 6'h01; ra = 32'h80000000; rb = 32'd1;
    tick();
    n_tests++;
    if (alu !== 32'h7FFFFFFF || ovf_q !== 1'b1) begin
      n_fail++; $display("FAIL sub_ovf: got alu=%h o=%b expected 7fffffff 1", alu, ovf_q);
    end
    op = 6'h03; ra = 32'h7FFFFFFF; rb = 32'd1;
    tick();
    n_tests++;
    if (ovf_q !== 1'b0) begin n_fail++; $display("FAIL or_no_ovf: got %b expected 0", ovf_q); end
  endtask

  task automatic test_mul_reset();
    idle_inputs(); op = 6'h0B; ra = 32'd3; rb = 32'd5; wb = 1'b1; rw = 5'd2;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; idle_inputs();
    tick();
    reset = 1'b0;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mulrst_stall: got %b expected 0", stall); end
    n_tests++;
    if ({alu, store, rw_q, wb_q, me_q, mrw_q, zero_q, ovf_q} !== 75'd0) begin
      n_fail++; $display("FAIL mulrst_outputs: got alu=%h store=%h rw=%0d wb=%b expected all 0", alu, store, rw_q, wb_q);
    end
    op = 6'h00; ra = 32'd2; rb = 32'd2; wb = 1'b1; rw = 5'd6;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mulrst_idle_stall: got %b expected 0", stall); end
    tick();
    n_tests++;
    if (alu !== 32'd4 || wb_q !== 1'b1) begin n_fail++; $display("FAIL mulrst_idle_add: got alu=%h wb=%b expected 4 1", alu, wb_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_add_sub();
    test_forward_dm();
    test_logic_imm();
    test_back_to_back_mul();
    test_overflow();
    test_mul_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
